// File: rtl/gpr_pkg.sv
// Shared types and elaboration helpers for the multi-port GPR file.
package gpr_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } gpr_state_t;

  // Address width for a given depth; a 2-entry file still needs one bit.
  function automatic int gpr_aw(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic bit gpr_rd_lat_ok(input int rd_lat);
    return (rd_lat == 0) || (rd_lat == 1);
  endfunction

  function automatic bit gpr_bypass_ok(input int bypass);
    return (bypass == 0) || (bypass == 1);
  endfunction

  function automatic bit gpr_shape_ok(input int depth, input int nrd, input int nwr);
    return (depth >= 2) && (nrd >= 1) && (nrd <= 8) && (nwr >= 1) && (nwr <= 4);
  endfunction

endpackage

// File: rtl/gpr_clr_seq.sv
// Post-reset clear sequencer: sweeps every entry to zero, then hands the
// array over to normal operation.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   CLEAR | writing entry[clr_ptr] = 0 each cycle, ready = 0
//   RUN   | array valid, ready = 1; only rst returns to CLEAR
module gpr_clr_seq
  import gpr_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  output logic          ready,
  output logic          clr_we,
  output logic [AW-1:0] clr_adr,
  output logic          run
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  gpr_state_t    state;
  logic [AW-1:0] clr_ptr;

  // Sweep clr_ptr from 0 to DEPTH-1; the last entry is written on the same edge that enters RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      ready   <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_ptr == LAST) begin
            state <= RUN;
            ready <= 1'b1;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
        RUN: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we  = (state == CLEAR);
  assign clr_adr = clr_ptr;
  assign run     = (state == RUN);

endmodule

// File: rtl/gpr_mp.sv
// Parametrised multi-port general-purpose register file with hardware clear,
// optional write-to-read bypass and optional registered read stage.
module gpr_mp
  import gpr_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int NRD    = 3,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  parameter int RD_LAT = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  output logic                            ready,
  input  logic [NRD*gpr_aw(DEPTH)-1:0]    rd_adr,
  output logic [NRD*WIDTH-1:0]            rd_dat,
  input  logic [NWR-1:0]                  wr_en,
  input  logic [NWR*gpr_aw(DEPTH)-1:0]    wr_adr,
  input  logic [NWR*WIDTH-1:0]            wr_dat
);

  localparam int            AW      = gpr_aw(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

  if (!gpr_rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("gpr_mp: RD_LAT must be 0 or 1");
  end
  if (!gpr_bypass_ok(BYPASS)) begin : g_bad_bypass
    $error("gpr_mp: BYPASS must be 0 or 1");
  end
  if (!gpr_shape_ok(DEPTH, NRD, NWR)) begin : g_bad_shape
    $error("gpr_mp: DEPTH >= 2, NRD in 1..8, NWR in 1..4 required");
  end

  logic [WIDTH-1:0]     mem [DEPTH];
  logic                 clr_we;
  logic                 run;
  logic [AW-1:0]        clr_adr;
  logic [NRD*WIDTH-1:0] rd_comb;

  // Addresses past the last entry exist only when DEPTH is not a power of two.
  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  gpr_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk     (clk),
    .rst     (rst),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_adr (clr_adr),
    .run     (run)
  );

  // Storage update: the clear sweep owns the array; in RUN later write ports override earlier ones.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_adr] <= '0;
    end else if (run && !rst) begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && in_range(wr_adr[j*AW +: AW])) begin
          mem[wr_adr[j*AW +: AW]] <= wr_dat[j*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Per-port read mux: stored entry, optionally replaced by a same-cycle write, forced to 0 outside RUN.
  always_comb begin
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] v;
    rd_comb = '0;
    a       = '0;
    v       = '0;
    for (int i = 0; i < NRD; i++) begin
      a = rd_adr[i*AW +: AW];
      v = '0;
      if (in_range(a)) begin
        v = mem[a];
        if (BYPASS != 0) begin
          for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && (wr_adr[j*AW +: AW] == a)) begin
              v = wr_dat[j*WIDTH +: WIDTH];
            end
          end
        end
      end
      if (run) begin
        rd_comb[i*WIDTH +: WIDTH] = v;
      end
    end
  end

  if (RD_LAT == 1) begin : g_rd_reg
    logic [NRD*WIDTH-1:0] rd_q;

    // Registered read stage; it samples the already-bypassed, CLEAR-gated value.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_q <= '0;
      end else begin
        rd_q <= rd_comb;
      end
    end

    assign rd_dat = rd_q;
  end else begin : g_rd_comb
    assign rd_dat = rd_comb;
  end

endmodule
